// File: rtl/post_spi_ctrl_gen.sv
// SPI slave that loads and inspects the Post machine code and tape memories.
// SPI pins are oversampled on a runtime-selectable clock-enable tick; no derived clocks.
module post_spi_ctrl_gen #(
   parameter int CW    = 4,
   parameter int DW    = 1,
   parameter int AW    = 8,
   parameter int DIV_W = 16,
   parameter int SEL_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [SEL_W-1:0] DIV_SEL,
   input  logic             CS,
   input  logic             SCK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [CW-1:0]    CIN,
   output logic [CW-1:0]    COUT,
   output logic [AW-1:0]    CADD,
   output logic             CWE,
   input  logic [DW-1:0]    DIN,
   output logic [DW-1:0]    DOUT,
   output logic [AW-1:0]    DADD,
   output logic             DWE,
   output logic             PEN,
   output logic             ERR
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] ADDR = 2'd2;
   localparam logic [1:0] DATA = 2'd3;

   localparam int NAB = (AW <= 8) ? 1 : 2;

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_mask;
   logic [SEL_W-1:0] sel_q;
   logic             tick;

   logic [1:0] cs_sync, sck_sync, mosi_sync;
   logic       cs_q, sck_q;
   logic       cs_fall, cs_rise, sck_rise, sck_fall;

   logic [1:0]    state;
   logic          in_frame;
   logic [2:0]    bit_cnt;
   logic          ab_cnt;
   logic [6:0]    rx;
   logic [7:0]    rx_byte;
   logic [7:0]    addr_hi;
   logic [AW-1:0] addr_new;
   logic [7:0]    tx;
   logic [1:0]    cap_cnt;
   logic          is_write, tgt;
   logic          wr_pend, inc_pend;

   // Tick when the low DIV_SEL counter bits are all ones; the select is latched on a tick
   // so a change only applies from the next wrap.
   assign div_mask = (DIV_W'(1) << sel_q) - DIV_W'(1);
   assign tick     = (div_cnt & div_mask) == div_mask;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         div_cnt <= '0;
         sel_q   <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         div_cnt <= div_cnt + DIV_W'(1);
         if (tick) sel_q <= DIV_SEL;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cs_sync   <= 2'b11;
         cs_q      <= 1'b1;
         sck_sync  <= 2'b00;
         sck_q     <= 1'b0;
         mosi_sync <= 2'b00;
      end else if (tick) begin
         cs_sync   <= {cs_sync[0], CS};
         cs_q      <= cs_sync[1];
         sck_sync  <= {sck_sync[0], SCK};
         sck_q     <= sck_sync[1];
         mosi_sync <= {mosi_sync[0], MOSI};
      end
   end

   assign cs_fall  = tick &  cs_q  & ~cs_sync[1];
   assign cs_rise  = tick & ~cs_q  &  cs_sync[1];
   assign sck_rise = tick & ~sck_q &  sck_sync[1];
   assign sck_fall = tick &  sck_q & ~sck_sync[1];

   assign in_frame = (state != IDLE);
   assign rx_byte  = {rx, mosi_sync[1]};
   assign addr_new = AW'({addr_hi, rx_byte});
   assign PEN      = in_frame;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         ab_cnt   <= 1'b0;
         rx       <= '0;
         addr_hi  <= '0;
         tx       <= '0;
         cap_cnt  <= '0;
         is_write <= 1'b0;
         tgt      <= 1'b0;
         wr_pend  <= 1'b0;
         inc_pend <= 1'b0;
         MISO     <= 1'b0;
         COUT     <= '0;
         CADD     <= '0;
         CWE      <= 1'b0;
         DOUT     <= '0;
         DADD     <= '0;
         DWE      <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         // Write path: data registered on byte completion, strobe on the next tick,
         // address bump on the first tick after the strobe has dropped.
         CWE <= 1'b0;
         DWE <= 1'b0;
         if (tick && wr_pend) begin
            wr_pend <= 1'b0;
            CWE     <= ~tgt;
            DWE     <= tgt;
         end
         if (CWE || DWE) inc_pend <= 1'b1;
         if (tick && inc_pend) begin
            inc_pend <= 1'b0;
            if (tgt) DADD <= DADD + AW'(1);
            else     CADD <= CADD + AW'(1);
         end

         // Read path: memory word captured two ticks after the address moves.
         if (tick && cap_cnt != 2'd0) begin
            cap_cnt <= cap_cnt - 2'd1;
            if (cap_cnt == 2'd1) tx <= tgt ? 8'(DIN) : 8'(CIN);
         end

         if (state != DATA || is_write) begin
            MISO <= 1'b0;
         end else if (sck_fall) begin
            MISO <= tx[7];
            tx   <= {tx[6:0], 1'b0};
         end

         if (in_frame && cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cap_cnt <= '0;
            if (bit_cnt != 3'd0) ERR <= 1'b1;
         end else if (!in_frame) begin
            if (cs_fall) begin
               state   <= CMD;
               ERR     <= 1'b0;
               bit_cnt <= '0;
               ab_cnt  <= 1'b0;
            end
         end else if (sck_rise) begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               case (state)
                  CMD: begin
                     is_write <= rx_byte[7];
                     tgt      <= rx_byte[6];
                     state    <= ADDR;
                  end
                  ADDR: begin
                     addr_hi <= rx_byte;
                     if (ab_cnt == 1'(NAB - 1)) begin
                        state <= DATA;
                        if (tgt) DADD <= addr_new;
                        else     CADD <= addr_new;
                        if (!is_write) cap_cnt <= 2'd2;
                     end else begin
                        ab_cnt <= ab_cnt + 1'b1;
                     end
                  end
                  DATA: begin
                     if (is_write) begin
                        if (tgt) DOUT <= rx_byte[DW-1:0];
                        else     COUT <= rx_byte[CW-1:0];
                        wr_pend <= 1'b1;
                     end else begin
                        if (tgt) DADD <= DADD + AW'(1);
                        else     CADD <= CADD + AW'(1);
                        cap_cnt <= 2'd2;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_post_spi_ctrl_gen.sv
// Bench for post_spi_ctrl_gen: drives SPI frames, scoreboards write strobes and read-back bytes.
module tb_post_spi_ctrl_gen;
   localparam int CW  = 4;
   localparam int DW  = 1;
   localparam int AW  = 8;
   localparam int AW2 = 12;

   typedef struct packed {
      logic        tgt;
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic           CLK = 1'b0;
   logic           RST = 1'b0;
   logic [3:0]     DIV_SEL = '0;
   logic           CS = 1'b1, CS2 = 1'b1, SCK = 1'b0, MOSI = 1'b0;
   logic           MISO, CWE, DWE, PEN, ERR;
   logic [CW-1:0]  CIN, COUT;
   logic [DW-1:0]  DIN, DOUT;
   logic [AW-1:0]  CADD, DADD;
   logic           MISO2, CWE2, DWE2, PEN2, ERR2;
   logic [CW-1:0]  CIN2 = '0, COUT2;
   logic [DW-1:0]  DIN2 = '0, DOUT2;
   logic [AW2-1:0] CADD2, DADD2;

   logic [CW-1:0] code_mem [256];
   logic [DW-1:0] data_mem [256];

   int n_checks = 0;
   int n_fail   = 0;
   int cwe_cnt = 0, dwe_cnt = 0, cwe2_cnt = 0;
   wr_t wq[$];
   wr_t wq2[$];

   assign CIN = code_mem[CADD];
   assign DIN = data_mem[DADD];

   post_spi_ctrl_gen #(.CW(CW), .DW(DW), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .DIV_SEL(DIV_SEL), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
      .CIN(CIN), .COUT(COUT), .CADD(CADD), .CWE(CWE), .DIN(DIN), .DOUT(DOUT), .DADD(DADD),
      .DWE(DWE), .PEN(PEN), .ERR(ERR)
   );

   post_spi_ctrl_gen #(.CW(CW), .DW(DW), .AW(AW2)) dut_wide (
      .CLK(CLK), .RST(RST), .DIV_SEL(DIV_SEL), .CS(CS2), .SCK(SCK), .MOSI(MOSI), .MISO(MISO2),
      .CIN(CIN2), .COUT(COUT2), .CADD(CADD2), .CWE(CWE2), .DIN(DIN2), .DOUT(DOUT2), .DADD(DADD2),
      .DWE(DWE2), .PEN(PEN2), .ERR(ERR2)
   );

   always #5 CLK = ~CLK;

   // Strobe monitor: pops the scoreboard on each strobe, checks hold before and after.
   logic          post_pend = 1'b0;
   logic          s_tgt;
   logic [AW-1:0] s_addr, prev_cadd, prev_dadd;
   logic [7:0]    s_data;
   logic [CW-1:0] prev_cout;
   logic [DW-1:0] prev_dout;

   always @(negedge CLK) begin : mon
      wr_t e;
      if (!RST) begin
         post_pend = 1'b0;
      end else begin
         if (post_pend) begin
            post_pend = 1'b0;
            n_checks++;
            if (CWE || DWE) begin
               n_fail++;
               $display("FAIL strobe_width: CWE=%b DWE=%b still high, required one-cycle pulse", CWE, DWE);
            end
            n_checks++;
            if (s_tgt ? (DADD !== s_addr || DOUT !== s_data[DW-1:0])
                      : (CADD !== s_addr || COUT !== s_data[CW-1:0])) begin
               n_fail++;
               $display("FAIL strobe_hold_after: addr %h/%h data %h/%h, required %h/%h",
                        CADD, DADD, COUT, DOUT, s_addr, s_data);
            end
         end
         if (CWE && DWE) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_exclusive: CWE=1 and DWE=1 together");
         end
         if (CWE || DWE) begin
            if (CWE) cwe_cnt++;
            if (DWE) dwe_cnt++;
            n_checks++;
            if (wq.size() == 0) begin
               n_fail++;
               $display("FAIL strobe_unexpected: CWE=%b DWE=%b CADD=%h DADD=%h, required none", CWE, DWE, CADD, DADD);
            end else begin
               e = wq.pop_front();
               if (DWE !== e.tgt || (e.tgt ? (DADD !== e.addr[AW-1:0] || DOUT !== e.data[DW-1:0])
                                           : (CADD !== e.addr[AW-1:0] || COUT !== e.data[CW-1:0]))) begin
                  n_fail++;
                  $display("FAIL strobe_value: DWE=%b CADD=%h COUT=%h DADD=%h DOUT=%h, required tgt=%b addr=%h data=%h",
                           DWE, CADD, COUT, DADD, DOUT, e.tgt, e.addr, e.data);
               end
            end
            n_checks++;
            if (DWE ? (prev_dadd !== DADD || prev_dout !== DOUT) : (prev_cadd !== CADD || prev_cout !== COUT)) begin
               n_fail++;
               $display("FAIL strobe_hold_before: prev %h/%h %h/%h now %h/%h %h/%h",
                        prev_cadd, prev_cout, prev_dadd, prev_dout, CADD, COUT, DADD, DOUT);
            end
            post_pend = 1'b1;
            s_tgt     = DWE;
            s_addr    = DWE ? DADD : CADD;
            s_data    = DWE ? 8'(DOUT) : 8'(COUT);
         end
         if (CWE2) begin
            cwe2_cnt++;
            n_checks++;
            if (wq2.size() == 0) begin
               n_fail++;
               $display("FAIL wide_strobe_unexpected: CADD2=%h, required none", CADD2);
            end else begin
               e = wq2.pop_front();
               if (CADD2 !== e.addr[AW2-1:0] || COUT2 !== e.data[CW-1:0]) begin
                  n_fail++;
                  $display("FAIL wide_strobe_value: CADD2=%h COUT2=%h, required %h/%h", CADD2, COUT2, e.addr, e.data);
               end
            end
         end
         if (DWE2) begin
            n_checks++;
            n_fail++;
            $display("FAIL wide_dwe_unexpected: DWE2=1, required 0");
         end
      end
      prev_cadd = CADD;
      prev_dadd = DADD;
      prev_cout = COUT;
      prev_dout = DOUT;
   end

   function automatic int half();
      return 6 << DIV_SEL;
   endfunction

   function automatic wr_t mk(input logic tgt, input logic [15:0] addr, input logic [7:0] data);
      wr_t w;
      w.tgt  = tgt;
      w.addr = addr;
      w.data = data;
      return w;
   endfunction

   task automatic wait_n(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic spi_byte(input int which, input logic [7:0] b, input int nbits, output logic [7:0] r);
      r = '0;
      for (int i = 0; i < nbits; i++) begin
         MOSI = b[7-i];
         wait_n(half());
         r[7-i] = (which != 0) ? MISO2 : MISO;
         SCK = 1'b1;
         wait_n(half());
         SCK = 1'b0;
      end
   endtask

   task automatic cs_low(input int which);
      if (which != 0) CS2 = 1'b0;
      else            CS  = 1'b0;
      wait_n(2 * half());
   endtask

   task automatic cs_high(input int which);
      wait_n(half());
      if (which != 0) CS2 = 1'b1;
      else            CS  = 1'b1;
      wait_n(4 * half());
   endtask

   task automatic test_reset();
      wait_n(3);
      n_checks++;
      if ({MISO, COUT, CADD, CWE, DOUT, DADD, DWE, PEN, ERR} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 0", {MISO, COUT, CADD, CWE, DOUT, DADD, DWE, PEN, ERR});
      end
      n_checks++;
      if ({MISO2, COUT2, CADD2, CWE2, DOUT2, DADD2, DWE2, PEN2, ERR2} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_wide: got %h, required 0", {MISO2, COUT2, CADD2, CWE2, DOUT2, DADD2, DWE2, PEN2, ERR2});
      end
      RST = 1'b1;
      wait_n(8);
   endtask

   task automatic test_code_write();
      logic [7:0] r;
      logic [7:0] dat [3];
      int c0, d0;
      dat = '{8'h03, 8'h0A, 8'h0F};
      DIV_SEL = 4'd0;
      wait_n(4);
      c0 = cwe_cnt;
      d0 = dwe_cnt;
      n_checks++;
      if (PEN !== 1'b0) begin n_fail++; $display("FAIL cw_pen_idle: got %b, required 0", PEN); end
      cs_low(0);
      n_checks++;
      if (PEN !== 1'b1) begin n_fail++; $display("FAIL cw_pen_frame: got %b, required 1", PEN); end
      spi_byte(0, 8'h80, 8, r);
      spi_byte(0, 8'h05, 8, r);
      for (int i = 0; i < 3; i++) begin
         wq.push_back(mk(1'b0, 16'(5 + i), dat[i]));
         spi_byte(0, dat[i], 8, r);
      end
      cs_high(0);
      n_checks++;
      if (PEN !== 1'b0) begin n_fail++; $display("FAIL cw_pen_end: got %b, required 0", PEN); end
      n_checks++;
      if (cwe_cnt - c0 != 3 || dwe_cnt != d0) begin
         n_fail++;
         $display("FAIL cw_strobe_count: CWE %0d DWE %0d, required 3 and 0", cwe_cnt - c0, dwe_cnt - d0);
      end
      n_checks++;
      if (wq.size() != 0) begin n_fail++; $display("FAIL cw_missing: %0d strobes outstanding, required 0", wq.size()); wq.delete(); end
      n_checks++;
      if (CADD !== 8'h08 || ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL cw_final: CADD=%h ERR=%b, required 08 and 0", CADD, ERR);
      end
   endtask

   task automatic test_data_write();
      logic [7:0] r;
      int c0, d0;
      DIV_SEL = 4'd3;
      wait_n(4);
      c0 = cwe_cnt;
      d0 = dwe_cnt;
      cs_low(0);
      spi_byte(0, 8'hC0, 8, r);
      spi_byte(0, 8'hFF, 8, r);
      wq.push_back(mk(1'b1, 16'h00FF, 8'h01));
      spi_byte(0, 8'h01, 8, r);
      wq.push_back(mk(1'b1, 16'h0000, 8'h00));
      spi_byte(0, 8'h00, 8, r);
      cs_high(0);
      n_checks++;
      if (dwe_cnt - d0 != 2 || cwe_cnt != c0) begin
         n_fail++;
         $display("FAIL dw_strobe_count: DWE %0d CWE %0d, required 2 and 0", dwe_cnt - d0, cwe_cnt - c0);
      end
      n_checks++;
      if (wq.size() != 0) begin n_fail++; $display("FAIL dw_missing: %0d strobes outstanding, required 0", wq.size()); wq.delete(); end
      n_checks++;
      if (DADD !== 8'h01 || PEN !== 1'b0) begin
         n_fail++;
         $display("FAIL dw_final: DADD=%h PEN=%b, required 01 and 0", DADD, PEN);
      end
   endtask

   task automatic test_code_read();
      logic [7:0] r, exp;
      logic [7:0] tx_b [4];
      logic [7:0] ex_b [4];
      logic [7:0] rq[$];
      int c0, d0;
      tx_b = '{8'h00, 8'h10, 8'h00, 8'h00};
      ex_b = '{8'h00, 8'h00, 8'(code_mem[8'h10]), 8'(code_mem[8'h11])};
      DIV_SEL = 4'd0;
      wait_n(16);
      c0 = cwe_cnt;
      d0 = dwe_cnt;
      cs_low(0);
      for (int i = 0; i < 4; i++) begin
         rq.push_back(ex_b[i]);
         spi_byte(0, tx_b[i], 8, r);
         exp = rq.pop_front();
         n_checks++;
         if (r !== exp) begin n_fail++; $display("FAIL rd_byte%0d: MISO byte %h, required %h", i, r, exp); end
      end
      cs_high(0);
      n_checks++;
      if (cwe_cnt != c0 || dwe_cnt != d0) begin
         n_fail++;
         $display("FAIL rd_no_strobe: CWE %0d DWE %0d, required 0 and 0", cwe_cnt - c0, dwe_cnt - d0);
      end
      n_checks++;
      if (MISO !== 1'b0 || PEN !== 1'b0 || CADD !== 8'h12) begin
         n_fail++;
         $display("FAIL rd_final: MISO=%b PEN=%b CADD=%h, required 0 0 12", MISO, PEN, CADD);
      end
   endtask

   task automatic test_abort();
      logic [7:0] r;
      int c0;
      DIV_SEL = 4'd0;
      wait_n(4);
      c0 = cwe_cnt;
      cs_low(0);
      spi_byte(0, 8'h80, 8, r);
      spi_byte(0, 8'h20, 8, r);
      wq.push_back(mk(1'b0, 16'h0020, 8'h05));
      spi_byte(0, 8'h05, 8, r);
      spi_byte(0, 8'hC3, 4, r);
      cs_high(0);
      n_checks++;
      if (cwe_cnt - c0 != 1 || wq.size() != 0) begin
         n_fail++;
         $display("FAIL ab_strobe_count: CWE %0d outstanding %0d, required 1 and 0", cwe_cnt - c0, wq.size());
         wq.delete();
      end
      n_checks++;
      if (ERR !== 1'b1 || PEN !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_flags: ERR=%b PEN=%b, required 1 and 0", ERR, PEN);
      end
      n_checks++;
      if (COUT !== 4'h5 || CADD !== 8'h21) begin
         n_fail++;
         $display("FAIL ab_partial: COUT=%h CADD=%h, required 5 and 21", COUT, CADD);
      end
      cs_low(0);
      n_checks++;
      if (ERR !== 1'b0 || PEN !== 1'b1) begin
         n_fail++;
         $display("FAIL ab_clear: ERR=%b PEN=%b, required 0 and 1", ERR, PEN);
      end
      cs_high(0);
      n_checks++;
      if (ERR !== 1'b0 || PEN !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_clean_end: ERR=%b PEN=%b, required 0 and 0", ERR, PEN);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] r;
      DIV_SEL = 4'd0;
      wait_n(4);
      cs_low(0);
      spi_byte(0, 8'h80, 8, r);
      spi_byte(0, 8'h30, 8, r);
      wq.push_back(mk(1'b0, 16'h0030, 8'h01));
      spi_byte(0, 8'h01, 8, r);
      spi_byte(0, 8'hFF, 3, r);
      wait_n(2);
      RST = 1'b0;
      #1;
      n_checks++;
      if ({MISO, COUT, CADD, CWE, DOUT, DADD, DWE, PEN, ERR} !== '0) begin
         n_fail++;
         $display("FAIL mr_outputs: got %h, required 0", {MISO, COUT, CADD, CWE, DOUT, DADD, DWE, PEN, ERR});
      end
      CS = 1'b1;
      wait_n(5);
      RST = 1'b1;
      wait_n(10);
      n_checks++;
      if (wq.size() != 0) begin n_fail++; $display("FAIL mr_missing: %0d strobes outstanding, required 0", wq.size()); wq.delete(); end
      test_code_write();
   endtask

   task automatic test_wide_addr();
      logic [7:0] r;
      int c0;
      DIV_SEL = 4'd0;
      wait_n(4);
      c0 = cwe2_cnt;
      cs_low(1);
      spi_byte(1, 8'h80, 8, r);
      spi_byte(1, 8'h0A, 8, r);
      spi_byte(1, 8'hBC, 8, r);
      wq2.push_back(mk(1'b0, 16'h0ABC, 8'h07));
      spi_byte(1, 8'h07, 8, r);
      cs_high(1);
      n_checks++;
      if (cwe2_cnt - c0 != 1 || wq2.size() != 0) begin
         n_fail++;
         $display("FAIL wa_strobe_count: CWE %0d outstanding %0d, required 1 and 0", cwe2_cnt - c0, wq2.size());
         wq2.delete();
      end
      n_checks++;
      if (CADD2 !== 12'hABD || PEN2 !== 1'b0) begin
         n_fail++;
         $display("FAIL wa_final: CADD2=%h PEN2=%b, required abd and 0", CADD2, PEN2);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         code_mem[i] = CW'(i * 3);
         data_mem[i] = '0;
      end
      code_mem[8'h10] = 4'h9;
      code_mem[8'h11] = 4'h6;
      test_reset();
      test_code_write();
      test_data_write();
      test_code_read();
      test_abort();
      test_mid_reset();
      test_wide_addr();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
